// File: rtl/oci_tb_pkg.sv
// Shared definitions for the per-core OCI trace capture monitor: state encoding,
// entry-count derivation and saturating arithmetic.
package oci_tb_pkg;

    localparam logic [1:0] StCapture = 2'd0;
    localparam logic [1:0] StDrain   = 2'd1;
    localparam logic [1:0] StDone    = 2'd2;

    // Each trace entry occupies two bits of the DCT buffer.
    function automatic int unsigned max_ent(input int unsigned dct_w);
        return dct_w / 2;
    endfunction

    // Adds b to a and clamps the result to the all-ones value of a w-bit field.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [63:0] lim;
        logic [63:0] sum;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sum = a + b;
        if ((sum > lim) || (sum < a)) begin
            return lim;
        end
        return sum;
    endfunction

endpackage

// File: rtl/oci_tb_sync_fifo.sv
// Synchronous FIFO with registered pointers and occupancy; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module oci_tb_sync_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam logic [AddrW:0] LvlFull = DEPTH[AddrW:0];
    localparam logic [AddrW:0] LvlOne = 1;
    localparam logic [AddrW-1:0] PtrOne = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LvlFull);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LvlOne;
            2'b01:   level_d = level_q - LvlOne;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: contents are only observable through a valid level.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/oci_trace_capture_monitor.sv
// Per-core OCI trace capture monitor: buffers flushed DCT trace words, drains them to a
// debug reader and runs the end-of-test capture/drain/done sequence with statistics.
module oci_trace_capture_monitor
    import oci_tb_pkg::*;
#(
    parameter int unsigned DCT_W = 30,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TOT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DCT_W-1:0]         dct_buffer,
    input  logic [CNT_W-1:0]         dct_count,
    input  logic                     dct_flush,
    input  logic                     test_ending,
    input  logic                     test_has_ended,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DCT_W+CNT_W-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [TOT_W-1:0]         total_entries,
    output logic [TOT_W-1:0]         drop_cnt,
    output logic                     count_err,
    output logic                     done
);

    localparam logic [CNT_W-1:0] MaxEnt = CNT_W'(max_ent(DCT_W));

    logic [1:0]       state_q, state_d;
    logic [TOT_W-1:0] total_q, total_d;
    logic [TOT_W-1:0] drop_q, drop_d;
    logic             err_q, err_d;

    logic             flush_nz, over_cnt, pop, accept, fifo_full, fifo_empty;
    logic [CNT_W-1:0] add_cnt;

    assign flush_nz = dct_flush && (dct_count != '0);
    assign over_cnt = dct_count > MaxEnt;
    assign pop      = rd_valid && rd_ready;
    assign accept   = flush_nz && (state_q == StCapture) && (!fifo_full || pop);
    assign add_cnt  = over_cnt ? MaxEnt : dct_count;

    oci_tb_sync_fifo #(
        .WIDTH (DCT_W + CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (accept),
        .wdata_i ({dct_count, dct_buffer}),
        .pop_i   (pop),
        .rdata_o (rd_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign rd_valid      = !fifo_empty;
    assign total_entries = total_q;
    assign drop_cnt      = drop_q;
    assign count_err     = err_q;
    assign done          = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StCapture: begin
                if (test_has_ended) begin
                    state_d = StDone;
                end else if (test_ending) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // No push can occur outside capture, so an empty FIFO means drained.
                if (test_has_ended || (fifo_level == '0)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StDone;
        endcase
    end

    always_comb begin
        total_d = total_q;
        drop_d  = drop_q;
        err_d   = err_q;
        if (accept) begin
            total_d = TOT_W'(sat_add(64'(total_q), 64'(add_cnt), TOT_W));
        end
        if (flush_nz && !accept) begin
            drop_d = TOT_W'(sat_add(64'(drop_q), 64'd1, TOT_W));
        end
        if (dct_flush && over_cnt) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StCapture;
            total_q <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_oci_trace_capture_monitor.sv
// Directed bench for oci_trace_capture_monitor: a vector table for the basic flows plus
// hand-written sequences for full-FIFO, early termination and mid-drain reset.
module tb_oci_trace_capture_monitor;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [29:0] dct_buffer = '0;
    logic [3:0]  dct_count = '0;
    logic        dct_flush = 1'b0;
    logic        test_ending = 1'b0;
    logic        test_has_ended = 1'b0;
    logic        rd_ready = 1'b0;

    logic        rd_valid;
    logic [33:0] rd_data;
    logic [4:0]  fifo_level;
    logic [31:0] total_entries, drop_cnt;
    logic        count_err, done;

    logic        b_rd_valid;
    logic [31:0] b_rd_data;
    logic [4:0]  b_fifo_level;
    logic [31:0] b_total, b_drop;
    logic        b_err, b_done;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    oci_trace_capture_monitor #(.DCT_W(30), .CNT_W(4), .DEPTH(16), .TOT_W(32)) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_flush      (dct_flush),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .fifo_level     (fifo_level),
        .total_entries  (total_entries),
        .drop_cnt       (drop_cnt),
        .count_err      (count_err),
        .done           (done)
    );

    // Narrower buffer: MAX_ENT = 14, so a count of 15 is out of range here.
    oci_trace_capture_monitor #(.DCT_W(28), .CNT_W(4), .DEPTH(16), .TOT_W(32)) u_dut_b (
        .clk            (clk),
        .reset_n        (reset_n),
        .dct_buffer     (dct_buffer[27:0]),
        .dct_count      (dct_count),
        .dct_flush      (dct_flush),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .rd_ready       (rd_ready),
        .rd_valid       (b_rd_valid),
        .rd_data        (b_rd_data),
        .fifo_level     (b_fifo_level),
        .total_entries  (b_total),
        .drop_cnt       (b_drop),
        .count_err      (b_err),
        .done           (b_done)
    );

    typedef struct {
        bit          rst_n;
        bit          flush;
        logic [3:0]  cnt;
        logic [29:0] buff;
        bit          ending;
        bit          rdy;
        bit          e_valid;
        logic [4:0]  e_level;
        logic [31:0] e_total;
        logic [31:0] e_drop;
        bit          e_err;
        bit          e_done;
        bit          chk_data;
        logic [33:0] e_data;
        logic [31:0] b_total_e;
        bit          b_err_e;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(bit rst_n, bit flush, logic [3:0] cnt, logic [29:0] buff,
                                bit ending, bit rdy, bit ev, logic [4:0] el,
                                logic [31:0] et, logic [31:0] ed, bit ee, bit edn,
                                bit cd, logic [33:0] edata, logic [31:0] bt, bit be);
        vec_t v;
        v.rst_n = rst_n; v.flush = flush; v.cnt = cnt; v.buff = buff;
        v.ending = ending; v.rdy = rdy; v.e_valid = ev; v.e_level = el;
        v.e_total = et; v.e_drop = ed; v.e_err = ee; v.e_done = edn;
        v.chk_data = cd; v.e_data = edata; v.b_total_e = bt; v.b_err_e = be;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rst_n, input bit flush, input logic [3:0] cnt,
                         input logic [29:0] buff, input bit ending, input bit ended,
                         input bit rdy);
        reset_n = rst_n; dct_flush = flush; dct_count = cnt; dct_buffer = buff;
        test_ending = ending; test_has_ended = ended; rd_ready = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        // Flow: ordered drain, count 0 ignored, out-of-range count, drop in DRAIN, done.
        vecs[0]  = mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 5, 30'hA05, 0, 0, 1, 1, 5, 0, 0, 0, 1, {4'd5, 30'hA05}, 5, 0);
        vecs[2]  = mk(1, 1, 7, 30'hA07, 0, 0, 1, 2, 12, 0, 0, 0, 1, {4'd5, 30'hA05}, 12, 0);
        vecs[3]  = mk(1, 1, 15, 30'hA0F, 0, 0, 1, 3, 27, 0, 0, 0, 1, {4'd5, 30'hA05}, 26, 1);
        vecs[4]  = mk(1, 0, 0, 0, 0, 1,       1, 2, 27, 0, 0, 0, 1, {4'd7, 30'hA07}, 26, 1);
        vecs[5]  = mk(1, 0, 0, 0, 0, 1,       1, 1, 27, 0, 0, 0, 1, {4'd15, 30'hA0F}, 26, 1);
        vecs[6]  = mk(1, 0, 0, 0, 0, 1,       0, 0, 27, 0, 0, 0, 0, 0, 26, 1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(1, 1, 0, 30'hB00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1, 1, 15, 30'hB0F, 0, 0, 1, 1, 15, 0, 0, 0, 1, {4'd15, 30'hB0F}, 14, 1);
        vecs[10] = mk(1, 1, 1, 30'hC01, 0, 0, 1, 2, 16, 0, 0, 0, 1, {4'd15, 30'hB0F}, 15, 1);
        vecs[11] = mk(1, 1, 2, 30'hC02, 0, 0, 1, 3, 18, 0, 0, 0, 0, 0, 17, 1);
        vecs[12] = mk(1, 1, 3, 30'hC03, 0, 0, 1, 4, 21, 0, 0, 0, 0, 0, 20, 1);
        vecs[13] = mk(1, 0, 0, 0, 1, 0,       1, 4, 21, 0, 0, 0, 0, 0, 20, 1);
        vecs[14] = mk(1, 1, 6, 30'hD06, 1, 0, 1, 4, 21, 1, 0, 0, 1, {4'd15, 30'hB0F}, 20, 1);
        vecs[15] = mk(1, 0, 0, 0, 1, 1,       1, 3, 21, 1, 0, 0, 1, {4'd1, 30'hC01}, 20, 1);
        vecs[16] = mk(1, 0, 0, 0, 1, 1,       1, 2, 21, 1, 0, 0, 1, {4'd2, 30'hC02}, 20, 1);
        vecs[17] = mk(1, 0, 0, 0, 1, 1,       1, 1, 21, 1, 0, 0, 1, {4'd3, 30'hC03}, 20, 1);
        vecs[18] = mk(1, 0, 0, 0, 1, 1,       0, 0, 21, 1, 0, 0, 0, 0, 20, 1);
        vecs[19] = mk(1, 0, 0, 0, 1, 1,       0, 0, 21, 1, 0, 1, 0, 0, 20, 1);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst_n, vecs[i].flush, vecs[i].cnt, vecs[i].buff,
                  vecs[i].ending, 1'b0, vecs[i].rdy);
            tick();
            chk($sformatf("v%0d rd_valid", i), 64'(rd_valid), 64'(vecs[i].e_valid));
            chk($sformatf("v%0d fifo_level", i), 64'(fifo_level), 64'(vecs[i].e_level));
            chk($sformatf("v%0d total", i), 64'(total_entries), 64'(vecs[i].e_total));
            chk($sformatf("v%0d drop", i), 64'(drop_cnt), 64'(vecs[i].e_drop));
            chk($sformatf("v%0d count_err", i), 64'(count_err), 64'(vecs[i].e_err));
            chk($sformatf("v%0d done", i), 64'(done), 64'(vecs[i].e_done));
            chk($sformatf("v%0d b_total", i), 64'(b_total), 64'(vecs[i].b_total_e));
            chk($sformatf("v%0d b_err", i), 64'(b_err), 64'(vecs[i].b_err_e));
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d rd_data", i), 64'(rd_data), 64'(vecs[i].e_data));
            end
        end

        // Fill past capacity, then push while full with a simultaneous pop.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b1, 4'd1, 30'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("full level", 64'(fifo_level), 64'd16);
        chk("full drop", 64'(drop_cnt), 64'd2);
        chk("full total", 64'(total_entries), 64'd16);
        chk("full head", 64'(rd_data), {30'd0, 4'd1, 30'd0});
        drive(1'b1, 1'b1, 4'd1, 30'h3F, 1'b0, 1'b0, 1'b1);
        tick();
        chk("full push+pop level", 64'(fifo_level), 64'd16);
        chk("full push+pop drop", 64'(drop_cnt), 64'd2);
        chk("full push+pop total", 64'(total_entries), 64'd17);
        chk("full push+pop head", 64'(rd_data), {30'd0, 4'd1, 30'd1});

        // test_ending and test_has_ended together: DONE wins, content stays readable.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 4'(i), 30'h500 + 30'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 4'd0, '0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("end done", 64'(done), 64'd1);
        chk("end level", 64'(fifo_level), 64'd3);
        drive(1'b1, 1'b1, 4'd4, 30'h504, 1'b1, 1'b1, 1'b0);
        tick();
        chk("end drop", 64'(drop_cnt), 64'd1);
        chk("end level2", 64'(fifo_level), 64'd3);
        chk("end total", 64'(total_entries), 64'd6);
        chk("end head", 64'(rd_data), {30'd0, 4'd1, 30'h501});
        drive(1'b1, 1'b0, 4'd0, '0, 1'b1, 1'b1, 1'b1);
        for (int i = 2; i <= 3; i++) begin
            tick();
            chk($sformatf("end pop%0d data", i), 64'(rd_data),
                {30'd0, 4'(i), 30'h500 + 30'(i)});
            chk($sformatf("end pop%0d level", i), 64'(fifo_level), 64'(4 - i));
        end
        tick();
        chk("end empty valid", 64'(rd_valid), 64'd0);
        chk("end still done", 64'(done), 64'd1);

        // Reset in the middle of a drain discards everything and returns to capture.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 4'd1, 30'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 4'd0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("mid level", 64'(fifo_level), 64'd5);
        chk("mid done", 64'(done), 64'd0);
        drive(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst valid", 64'(rd_valid), 64'd0);
        chk("rst level", 64'(fifo_level), 64'd0);
        chk("rst total", 64'(total_entries), 64'd0);
        chk("rst drop", 64'(drop_cnt), 64'd0);
        chk("rst err", 64'(count_err), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        drive(1'b1, 1'b1, 4'd2, 30'h77, 1'b0, 1'b0, 1'b0);
        tick();
        chk("post-rst level", 64'(fifo_level), 64'd1);
        chk("post-rst total", 64'(total_entries), 64'd2);
        chk("post-rst drop", 64'(drop_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
